// File: rtl/cdb_arbiter_pkg.sv
// Shared configuration for the CDB arbiter slice: RoB tag width, source
// encodings on cdb_src, and the default per-source queue depth.
package cdb_arbiter_pkg;

  localparam int   ROB_SIZE_WIDTH = 4;
  localparam int   CDB_QDEPTH     = 2;
  localparam logic CDB_SRC_ALU    = 1'b0;
  localparam logic CDB_SRC_LSB    = 1'b1;

endpackage

// File: rtl/cdb_src_queue.sv
// In-order result queue for one CDB producer. Presents either its head or the
// incoming result (bypass when empty) as the arbitration candidate.
module cdb_src_queue
  import cdb_arbiter_pkg::*;
#(
  parameter int ID_W   = ROB_SIZE_WIDTH,
  parameter int DATA_W = 32,
  parameter int QDEPTH = CDB_QDEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [ID_W-1:0]   in_rob_id,
  input  logic [DATA_W-1:0] in_value,
  input  logic              grant,
  output logic              req,
  output logic [ID_W-1:0]   cand_rob_id,
  output logic [DATA_W-1:0] cand_value,
  output logic              full
);

  localparam int PTR_W = $clog2(QDEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ID_W-1:0]   id_mem   [QDEPTH];
  logic [DATA_W-1:0] data_mem [QDEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_next;
  logic              empty;
  logic              at_cap;
  logic              enq;
  logic              deq;

  assign empty       = (count == '0);
  assign at_cap      = (count == CNT_W'(QDEPTH));
  assign req         = ~empty | in_valid;
  assign cand_rob_id = empty ? in_rob_id : id_mem[head];
  assign cand_value  = empty ? in_value  : data_mem[head];
  assign deq         = grant & ~empty;
  // A granted input on an empty queue goes straight to the bus; a full queue
  // can still take one more result when its head leaves in the same cycle.
  assign enq         = in_valid & ~(grant & empty) & ~(at_cap & ~deq);

  always_comb begin
    count_next = count;
    if (clear)
      count_next = '0;
    else
      count_next = count + CNT_W'(enq) - CNT_W'(deq);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      full  <= 1'b0;
    end else if (rdy) begin
      if (clear) begin
        head <= '0;
        tail <= '0;
      end else begin
        if (enq) tail <= tail + PTR_W'(1);
        if (deq) head <= head + PTR_W'(1);
      end
      count <= count_next;
      full  <= (count_next >= CNT_W'(QDEPTH - 1));
    end
  end

  always_ff @(posedge clk) begin
    if (rdy && !clear && enq) begin
      id_mem[tail]   <= in_rob_id;
      data_mem[tail] <= in_value;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst && rdy && !clear && in_valid && at_cap && !deq)
      $error("cdb_src_queue: result tag %0d dropped, queue full", in_rob_id);
  end
`endif

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing the registered CDB between the ALU and the LSB.
// Define CDB_STATS_EN to add broadcast and conflict statistics counters.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int ROB_ID_W = ROB_SIZE_WIDTH,
  parameter int DATA_W   = 32,
  parameter int QDEPTH   = CDB_QDEPTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                rob_clear,
  input  logic                alu_valid,
  input  logic [ROB_ID_W-1:0] alu_rob_id,
  input  logic [DATA_W-1:0]   alu_value,
  output logic                alu_full,
  input  logic                lsb_valid,
  input  logic [ROB_ID_W-1:0] lsb_rob_id,
  input  logic [DATA_W-1:0]   lsb_value,
  output logic                lsb_full,
  output logic                cdb_valid,
  output logic [ROB_ID_W-1:0] cdb_rob_id,
  output logic [DATA_W-1:0]   cdb_value,
  output logic                cdb_src
`ifdef CDB_STATS_EN
  ,
  output logic [31:0]         stat_bcast_cnt,
  output logic [31:0]         stat_conflict_cnt
`endif
);

  logic                alu_req;
  logic                lsb_req;
  logic                alu_grant;
  logic                lsb_grant;
  logic                last_grant;
  logic [ROB_ID_W-1:0] alu_cand_id;
  logic [ROB_ID_W-1:0] lsb_cand_id;
  logic [DATA_W-1:0]   alu_cand_value;
  logic [DATA_W-1:0]   lsb_cand_value;

  cdb_src_queue #(.ID_W(ROB_ID_W), .DATA_W(DATA_W), .QDEPTH(QDEPTH)) alu_queue (
    .clk         (clk),
    .rst         (rst),
    .rdy         (rdy),
    .clear       (rob_clear),
    .in_valid    (alu_valid),
    .in_rob_id   (alu_rob_id),
    .in_value    (alu_value),
    .grant       (alu_grant),
    .req         (alu_req),
    .cand_rob_id (alu_cand_id),
    .cand_value  (alu_cand_value),
    .full        (alu_full)
  );

  cdb_src_queue #(.ID_W(ROB_ID_W), .DATA_W(DATA_W), .QDEPTH(QDEPTH)) lsb_queue (
    .clk         (clk),
    .rst         (rst),
    .rdy         (rdy),
    .clear       (rob_clear),
    .in_valid    (lsb_valid),
    .in_rob_id   (lsb_rob_id),
    .in_value    (lsb_value),
    .grant       (lsb_grant),
    .req         (lsb_req),
    .cand_rob_id (lsb_cand_id),
    .cand_value  (lsb_cand_value),
    .full        (lsb_full)
  );

  // On a tie the source that did not win last time gets the bus.
  assign alu_grant = rdy & ~rob_clear & alu_req & (~lsb_req | (last_grant == CDB_SRC_LSB));
  assign lsb_grant = rdy & ~rob_clear & lsb_req & ~alu_grant;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cdb_valid  <= 1'b0;
      cdb_rob_id <= '0;
      cdb_value  <= '0;
      cdb_src    <= 1'b0;
      last_grant <= CDB_SRC_LSB;
    end else if (rdy) begin
      cdb_valid <= alu_grant | lsb_grant;
      if (alu_grant) begin
        cdb_rob_id <= alu_cand_id;
        cdb_value  <= alu_cand_value;
        cdb_src    <= CDB_SRC_ALU;
        last_grant <= CDB_SRC_ALU;
      end else if (lsb_grant) begin
        cdb_rob_id <= lsb_cand_id;
        cdb_value  <= lsb_cand_value;
        cdb_src    <= CDB_SRC_LSB;
        last_grant <= CDB_SRC_LSB;
      end
    end
  end

`ifdef CDB_STATS_EN
  // Statistics survive a RoB flush; only the hard reset clears them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_bcast_cnt    <= '0;
      stat_conflict_cnt <= '0;
    end else if (rdy) begin
      if (cdb_valid)
        stat_bcast_cnt <= stat_bcast_cnt + 32'd1;
      if (alu_req && lsb_req)
        stat_conflict_cnt <= stat_conflict_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Testbench for cdb_arbiter: directed scenarios plus randomized traffic checked
// against a queue-based reference model of the arbitration rules.
module tb_cdb_arbiter;

  localparam int ID_W = 4;
  localparam int DW   = 32;
  localparam int QD   = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            rdy;
  logic            rob_clear;
  logic            alu_valid;
  logic [ID_W-1:0] alu_rob_id;
  logic [DW-1:0]   alu_value;
  logic            alu_full;
  logic            lsb_valid;
  logic [ID_W-1:0] lsb_rob_id;
  logic [DW-1:0]   lsb_value;
  logic            lsb_full;
  logic            cdb_valid;
  logic [ID_W-1:0] cdb_rob_id;
  logic [DW-1:0]   cdb_value;
  logic            cdb_src;
`ifdef CDB_STATS_EN
  logic [31:0]     stat_bcast_cnt;
  logic [31:0]     stat_conflict_cnt;
`endif

  always #5 clk = ~clk;

  cdb_arbiter #(.ROB_ID_W(ID_W), .DATA_W(DW), .QDEPTH(QD)) dut (
    .clk        (clk),
    .rst        (rst),
    .rdy        (rdy),
    .rob_clear  (rob_clear),
    .alu_valid  (alu_valid),
    .alu_rob_id (alu_rob_id),
    .alu_value  (alu_value),
    .alu_full   (alu_full),
    .lsb_valid  (lsb_valid),
    .lsb_rob_id (lsb_rob_id),
    .lsb_value  (lsb_value),
    .lsb_full   (lsb_full),
    .cdb_valid  (cdb_valid),
    .cdb_rob_id (cdb_rob_id),
    .cdb_value  (cdb_value),
`ifdef CDB_STATS_EN
    .stat_bcast_cnt    (stat_bcast_cnt),
    .stat_conflict_cnt (stat_conflict_cnt),
`endif
    .cdb_src    (cdb_src)
  );

  // Reference model: one SV queue per source, results leave in arrival order.
  logic [ID_W-1:0] ma_id[$];
  logic [DW-1:0]   ma_val[$];
  logic [ID_W-1:0] ml_id[$];
  logic [DW-1:0]   ml_val[$];
  bit              m_last_lsb;
  bit              e_valid;
  bit              e_src;
  bit              e_afull;
  bit              e_lfull;
  logic [ID_W-1:0] e_id;
  logic [DW-1:0]   e_val;

  int checks = 0;
  int passes = 0;

  task automatic model_reset();
    ma_id.delete(); ma_val.delete(); ml_id.delete(); ml_val.delete();
    m_last_lsb = 1'b1;
    e_valid = 1'b0; e_src = 1'b0; e_afull = 1'b0; e_lfull = 1'b0;
    e_id = '0; e_val = '0;
  endtask

  task automatic model_step(input bit r, input bit c,
                            input bit av, input logic [ID_W-1:0] aid, input logic [DW-1:0] aval,
                            input bit lv, input logic [ID_W-1:0] lid, input logic [DW-1:0] lval);
    bit ar, lr, ga, gl;
    if (!r) return;
    if (c) begin
      ma_id.delete(); ma_val.delete(); ml_id.delete(); ml_val.delete();
      e_valid = 1'b0; e_afull = 1'b0; e_lfull = 1'b0;
      return;
    end
    ar = (ma_id.size() > 0) || av;
    lr = (ml_id.size() > 0) || lv;
    ga = ar && (!lr || m_last_lsb);
    gl = lr && !ga;
    if (av && !(ma_id.size() == QD && !ga)) begin ma_id.push_back(aid); ma_val.push_back(aval); end
    if (lv && !(ml_id.size() == QD && !gl)) begin ml_id.push_back(lid); ml_val.push_back(lval); end
    if (ga) begin
      e_id = ma_id.pop_front(); e_val = ma_val.pop_front(); e_src = 1'b0; m_last_lsb = 1'b0;
    end else if (gl) begin
      e_id = ml_id.pop_front(); e_val = ml_val.pop_front(); e_src = 1'b1; m_last_lsb = 1'b1;
    end
    e_valid = ga || gl;
    e_afull = ma_id.size() >= QD - 1;
    e_lfull = ml_id.size() >= QD - 1;
  endtask

  task automatic cycle(input bit r, input bit c,
                       input bit av, input logic [ID_W-1:0] aid, input logic [DW-1:0] aval,
                       input bit lv, input logic [ID_W-1:0] lid, input logic [DW-1:0] lval);
    @(negedge clk);
    rdy = r; rob_clear = c;
    alu_valid = av; alu_rob_id = aid; alu_value = aval;
    lsb_valid = lv; lsb_rob_id = lid; lsb_value = lval;
    @(posedge clk);
    model_step(r, c, av, aid, aval, lv, lid, lval);
    #1;
  endtask

  task automatic idle();
    cycle(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  task automatic drive_idle_inputs();
    rdy = 1'b1; rob_clear = 1'b0;
    alu_valid = 1'b0; alu_rob_id = '0; alu_value = '0;
    lsb_valid = 1'b0; lsb_rob_id = '0; lsb_value = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    drive_idle_inputs();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0;
    drive_idle_inputs();
    model_reset();
    #7;
    checks++; if (cdb_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b expected 0", cdb_valid); else passes++;
    checks++; if (cdb_rob_id !== '0) $display("[TB] FAIL reset_id: got %0h expected 0", cdb_rob_id); else passes++;
    checks++; if (cdb_value !== '0) $display("[TB] FAIL reset_value: got %0h expected 0", cdb_value); else passes++;
    checks++; if (cdb_src !== 1'b0) $display("[TB] FAIL reset_src: got %b expected 0", cdb_src); else passes++;
    checks++; if (alu_full !== 1'b0) $display("[TB] FAIL reset_alu_full: got %b expected 0", alu_full); else passes++;
    checks++; if (lsb_full !== 1'b0) $display("[TB] FAIL reset_lsb_full: got %b expected 0", lsb_full); else passes++;
`ifdef CDB_STATS_EN
    checks++; if (stat_bcast_cnt !== 32'd0) $display("[TB] FAIL reset_stat_bcast: got %0d expected 0", stat_bcast_cnt); else passes++;
    checks++; if (stat_conflict_cnt !== 32'd0) $display("[TB] FAIL reset_stat_conflict: got %0d expected 0", stat_conflict_cnt); else passes++;
`endif
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_alu_only();
    do_reset();
    idle();
    cycle(1'b1, 1'b0, 1'b1, 4'd3, 32'h11, 1'b0, '0, '0);
    checks++; if (cdb_valid !== 1'b1) $display("[TB] FAIL alu_only_valid: got %b expected 1", cdb_valid); else passes++;
    checks++; if (cdb_rob_id !== 4'd3) $display("[TB] FAIL alu_only_id: got %0d expected 3", cdb_rob_id); else passes++;
    checks++; if (cdb_value !== 32'h11) $display("[TB] FAIL alu_only_value: got %0h expected 11", cdb_value); else passes++;
    checks++; if (cdb_src !== 1'b0) $display("[TB] FAIL alu_only_src: got %b expected 0", cdb_src); else passes++;
    idle();
    checks++; if (cdb_valid !== 1'b0) $display("[TB] FAIL alu_only_drop_valid: got %b expected 0", cdb_valid); else passes++;
    checks++; if (cdb_rob_id !== 4'd3) $display("[TB] FAIL alu_only_hold_id: got %0d expected 3", cdb_rob_id); else passes++;
  endtask

  task automatic test_tie();
    do_reset();
    cycle(1'b1, 1'b0, 1'b1, 4'd1, 32'hA, 1'b1, 4'd2, 32'hB);
    checks++; if (cdb_valid !== 1'b1 || cdb_src !== 1'b0 || cdb_rob_id !== 4'd1 || cdb_value !== 32'hA)
      $display("[TB] FAIL tie_first: got v=%b src=%b id=%0d val=%0h expected v=1 src=0 id=1 val=a",
               cdb_valid, cdb_src, cdb_rob_id, cdb_value);
    else passes++;
    checks++; if (lsb_full !== e_lfull) $display("[TB] FAIL tie_lsb_full: got %b expected %b", lsb_full, e_lfull); else passes++;
    idle();
    checks++; if (cdb_valid !== 1'b1 || cdb_src !== 1'b1 || cdb_rob_id !== 4'd2 || cdb_value !== 32'hB)
      $display("[TB] FAIL tie_second: got v=%b src=%b id=%0d val=%0h expected v=1 src=1 id=2 val=b",
               cdb_valid, cdb_src, cdb_rob_id, cdb_value);
    else passes++;
    checks++; if (lsb_full !== 1'b0) $display("[TB] FAIL tie_lsb_drained: got %b expected 0", lsb_full); else passes++;
    idle();
    checks++; if (cdb_valid !== 1'b0) $display("[TB] FAIL tie_idle: got %b expected 0", cdb_valid); else passes++;
  endtask

  task automatic test_conflict();
    int n_bc;
    int exp_v;
    bit alt_ok, ord_ok, val_ok, model_ok, prev_src, seen_afull, seen_lfull;
    logic [ID_W-1:0] a_seen[$];
    logic [ID_W-1:0] l_seen[$];
    do_reset();
    n_bc = 0; alt_ok = 1; ord_ok = 1; val_ok = 1; model_ok = 1; prev_src = 1;
    seen_afull = 0; seen_lfull = 0;
    for (int k = 0; k < 10; k++) begin
      if (k < 4) cycle(1'b1, 1'b0, 1'b1, ID_W'(k), 32'h100 + k, 1'b1, ID_W'(8 + k), 32'h200 + k);
      else idle();
      if (cdb_valid !== e_valid || (e_valid && (cdb_rob_id !== e_id || cdb_src !== e_src))) model_ok = 0;
      if (alu_full === 1'b1) seen_afull = 1;
      if (lsb_full === 1'b1) seen_lfull = 1;
      if (cdb_valid === 1'b1) begin
        n_bc++;
        if (cdb_src === prev_src) alt_ok = 0;
        prev_src = cdb_src;
        exp_v = cdb_src ? 32'h200 + int'(cdb_rob_id) - 8 : 32'h100 + int'(cdb_rob_id);
        if (cdb_value !== DW'(exp_v)) val_ok = 0;
        if (cdb_src) l_seen.push_back(cdb_rob_id); else a_seen.push_back(cdb_rob_id);
      end
    end
    if (a_seen.size() != 4 || l_seen.size() != 4) ord_ok = 0;
    else for (int i = 0; i < 4; i++) if (a_seen[i] != ID_W'(i) || l_seen[i] != ID_W'(8 + i)) ord_ok = 0;
    checks++; if (n_bc != 8) $display("[TB] FAIL conflict_count: got %0d expected 8", n_bc); else passes++;
    checks++; if (!alt_ok) $display("[TB] FAIL conflict_alternate: got 0 expected 1"); else passes++;
    checks++; if (!ord_ok) $display("[TB] FAIL conflict_order: got alu=%0d lsb=%0d results expected 4 each in order", a_seen.size(), l_seen.size()); else passes++;
    checks++; if (!val_ok) $display("[TB] FAIL conflict_values: got 0 expected 1"); else passes++;
    checks++; if (!model_ok) $display("[TB] FAIL conflict_model: got 0 expected 1"); else passes++;
    checks++; if (!seen_afull || !seen_lfull) $display("[TB] FAIL conflict_full_seen: got alu=%b lsb=%b expected 1 1", seen_afull, seen_lfull); else passes++;
  endtask

  task automatic test_flush();
    bit stray;
    do_reset();
    cycle(1'b1, 1'b0, 1'b1, 4'd1, 32'h1, 1'b1, 4'd2, 32'h2);
    cycle(1'b1, 1'b0, 1'b1, 4'd3, 32'h3, 1'b1, 4'd4, 32'h4);
    cycle(1'b1, 1'b1, 1'b1, 4'd7, 32'h77, 1'b0, '0, '0);
    checks++; if (cdb_valid !== 1'b0) $display("[TB] FAIL flush_valid: got %b expected 0", cdb_valid); else passes++;
    checks++; if (alu_full !== 1'b0 || lsb_full !== 1'b0) $display("[TB] FAIL flush_full: got %b%b expected 00", alu_full, lsb_full); else passes++;
    stray = 0;
    for (int k = 0; k < 4; k++) begin
      idle();
      if (cdb_valid !== 1'b0) stray = 1;
    end
    checks++; if (stray) $display("[TB] FAIL flush_stray: got 1 expected 0"); else passes++;
  endtask

  task automatic test_rdy_freeze();
    bit frozen_ok;
    do_reset();
    cycle(1'b1, 1'b0, 1'b1, 4'd4, 32'h40, 1'b1, 4'd5, 32'h50);
    checks++; if (cdb_valid !== 1'b1 || cdb_rob_id !== 4'd4) $display("[TB] FAIL freeze_pre: got v=%b id=%0d expected v=1 id=4", cdb_valid, cdb_rob_id); else passes++;
    frozen_ok = 1;
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, 1'b0, 1'b1, ID_W'(k + 10), 32'hE0 + k, 1'b1, ID_W'(k + 13), 32'hF0 + k);
      if (cdb_valid !== 1'b1 || cdb_rob_id !== 4'd4 || cdb_value !== 32'h40 || cdb_src !== 1'b0 ||
          lsb_full !== e_lfull || alu_full !== e_afull) frozen_ok = 0;
    end
    checks++; if (!frozen_ok) $display("[TB] FAIL freeze_hold: got 0 expected 1"); else passes++;
    idle();
    checks++; if (cdb_valid !== 1'b1 || cdb_src !== 1'b1 || cdb_rob_id !== 4'd5 || cdb_value !== 32'h50)
      $display("[TB] FAIL freeze_resume: got v=%b src=%b id=%0d val=%0h expected v=1 src=1 id=5 val=50",
               cdb_valid, cdb_src, cdb_rob_id, cdb_value);
    else passes++;
    idle();
    checks++; if (cdb_valid !== 1'b0) $display("[TB] FAIL freeze_after: got %b expected 0", cdb_valid); else passes++;
  endtask

  task automatic test_async_reset();
    do_reset();
    cycle(1'b1, 1'b0, 1'b1, 4'd6, 32'h66, 1'b1, 4'd7, 32'h77);
    cycle(1'b1, 1'b0, 1'b1, 4'd8, 32'h88, 1'b1, 4'd9, 32'h99);
    checks++; if (cdb_valid !== 1'b1 || alu_full !== 1'b1 || lsb_full !== 1'b1)
      $display("[TB] FAIL areset_pre: got v=%b af=%b lf=%b expected 1 1 1", cdb_valid, alu_full, lsb_full);
    else passes++;
    #2;
    rst = 1'b0;
    drive_idle_inputs();
    model_reset();
    #1;
    checks++; if (cdb_valid !== 1'b0 || cdb_rob_id !== '0 || cdb_value !== '0 || cdb_src !== 1'b0)
      $display("[TB] FAIL areset_bus: got v=%b id=%0d val=%0h src=%b expected all 0", cdb_valid, cdb_rob_id, cdb_value, cdb_src);
    else passes++;
    checks++; if (alu_full !== 1'b0 || lsb_full !== 1'b0) $display("[TB] FAIL areset_full: got %b%b expected 00", alu_full, lsb_full); else passes++;
    @(negedge clk);
    rst = 1'b1;
    idle();
    checks++; if (cdb_valid !== 1'b0) $display("[TB] FAIL areset_empty: got %b expected 0", cdb_valid); else passes++;
  endtask

  task automatic test_random();
    bit r, c, av, lv;
    int bad;
    do_reset();
    bad = 0;
    for (int k = 0; k < 400; k++) begin
      r  = ($urandom_range(0, 9) != 0);
      c  = ($urandom_range(0, 24) == 0);
      av = !e_afull && ($urandom_range(0, 1) == 1);
      lv = !e_lfull && ($urandom_range(0, 2) != 0);
      cycle(r, c, av, ID_W'($urandom_range(0, 15)), DW'($urandom),
            lv, ID_W'($urandom_range(0, 15)), DW'($urandom));
      checks++;
      if (cdb_valid !== e_valid || cdb_rob_id !== e_id || cdb_value !== e_val ||
          (e_valid && cdb_src !== e_src) || alu_full !== e_afull || lsb_full !== e_lfull) begin
        bad++;
        if (bad <= 10)
          $display("[TB] FAIL random_cycle_%0d: got v=%b id=%0d val=%0h src=%b af=%b lf=%b expected v=%b id=%0d val=%0h src=%b af=%b lf=%b",
                   k, cdb_valid, cdb_rob_id, cdb_value, cdb_src, alu_full, lsb_full,
                   e_valid, e_id, e_val, e_src, e_afull, e_lfull);
      end else passes++;
    end
  endtask

  initial begin
    rst = 1'b1;
    drive_idle_inputs();
    test_reset();
    test_alu_only();
    test_tie();
    test_conflict();
    test_flush();
    test_rdy_freeze();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
